fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle main controller.
- Owns the PC register and the instruction-memory request/response handshake.
- Presents one instruction at a time (opcode/func3 fields feed the controller) and retires it when the datapath accepts it.
- Next PC is selected from the controller's 2-bit pc_src; fetch misalignment and memory timeout trap the block into a sticky halt.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles waiting for imem_rvalid before bus error.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  XLEN  request address (= pc).
- imem_ready  in  1  memory accepts request this cycle when imem_req&&imem_ready.
- imem_rvalid  in  1  read data valid (single-cycle pulse).
- imem_rdata  in  32  instruction word.
- instr  out  32  current instruction, stable while instr_valid.
- instr_valid  out  1  instr/pc/pc_plus4 valid for execution.
- exec_ready  in  1  datapath executes and retires instr this cycle.
- pc  out  XLEN  PC of current instruction.
- pc_plus4  out  XLEN  pc + 4, wraps modulo 2^XLEN.
- pc_src  in  2  next-PC select from controller: 00 pc+4, 01 pc+imm_ext, 10 alu_result, 11 treated as 00.
- imm_ext  in  XLEN  sign-extended immediate (branch/jal offset).
- alu_result  in  XLEN  jalr target.
- fault  out  1  sticky: halted on error.
- fault_cause  out  2  00 none, 01 misaligned target, 10 memory timeout.

Behaviour:
- Reset (rst high at clk edge, any state, including mid-wait):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, instr=0, instr_valid=0, fault=0, fault_cause=00, timeout counter=0.
  - A response arriving after reset from a pre-reset request is discarded; track this with an outstanding flag cleared by reset and ignore rvalid while not in WAIT.
- States: FETCH, WAIT, ISSUE, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 -> WAIT, counter cleared.
  - Otherwise hold FETCH with the request and address stable.
- WAIT:
  - imem_req=0, counter increments each cycle.
  - imem_rvalid=1 -> latch instr=imem_rdata -> ISSUE. instr_valid rises the next cycle (registered); minimum fetch latency is 2 cycles from request acceptance.
  - Counter reaches TIMEOUT without rvalid -> HALT, fault_cause=10.
  - If rvalid arrives in the same cycle the counter reaches TIMEOUT, rvalid wins.
- ISSUE:
  - instr_valid=1; instr/pc held until exec_ready=1.
  - On exec_ready, next PC is computed:
    - 00/11: pc+4.
    - 01: pc+imm_ext.
    - 10: {alu_result[XLEN-1:1],1'b0}.
  - All additions wrap modulo 2^XLEN.
  - Next PC [1:0]!=00 -> HALT with fault_cause=01; pc is not updated (it keeps the faulting instruction's PC).
  - Otherwise pc<=next PC, go to FETCH, instr_valid=0.
- pc_src is sampled only in the exec_ready cycle; it is ignored otherwise.
- Throughput: one instruction per 3 cycles minimum (FETCH, WAIT, ISSUE); no prefetch.
- HALT:
  - imem_req=0, instr_valid=0, fault=1; outputs frozen.
  - Only rst exits.
- imem_rvalid outside WAIT is ignored. exec_ready outside ISSUE is ignored.

Decomposition:
- Shared package (riscv_pkg) holds:
  - pc_src encodings: PC_PLUS4, PC_BRANCH, PC_JALR.
  - fault_cause encodings.
  - fetch state enum.
  - XLEN default.
- Sub-module next_pc_sel: combinational next-PC adder/mux plus misalignment check. Reused by later pipelined variants.

Test Plan:
- Reset then imem_ready=1, rvalid 1 cycle later with rdata=32'h00500093, exec_ready=1 with pc_src=00 -> instr_valid on cycle 3, pc goes 0 -> 4, next imem_addr=4.
- pc=8, pc_src=01, imm_ext=32'hFFFF_FFF8 -> next imem_addr=0. Then pc=0, imm_ext=-4 -> wraps to 32'hFFFF_FFFC with no fault.
- pc_src=10, alu_result=32'h0000_0103 -> pc=32'h102 -> HALT with fault_cause=01, pc stays at the old value, imem_req=0.
- imem_ready low for 5 cycles -> imem_req/imem_addr held stable; request accepted on the 6th cycle.
- TIMEOUT=4 with no rvalid -> fault=1, fault_cause=10 after 4 WAIT cycles. Late rvalid is ignored; rst returns pc=RESET_PC and fault=0.
- rst asserted in WAIT, rvalid arriving the cycle after reset -> ignored, new request issued at RESET_PC. exec_ready held low for 10 cycles in ISSUE -> instr/pc stable throughout.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the fetch stage: next-PC select, fault causes and FSM states.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_WAIT  = 2'd1;
  localparam fetch_state_t ST_ISSUE = 2'd2;
  localparam fetch_state_t ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN_DEFAULT
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC adder/mux with word-alignment check on the selected target.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    next_pc  = pc_plus4;
    case (pc_src)
      PC_BRANCH: next_pc = pc + imm_ext;
      // jalr target drops bit 0 before the alignment check
      PC_JALR:   next_pc = alu_result & ~XLEN'(1);
      default:   next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs the imem handshake, issues one instruction at a time
// and halts stickily on misaligned targets or memory timeout.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              exec_ready,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  input  logic [1:0]        pc_src,
  input  logic [XLEN-1:0]   imm_ext,
  input  logic [XLEN-1:0]   alu_result,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  fetch_state_t    state;
  logic [CW-1:0]   count;
  logic            outstanding;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            resp;
  logic            expire;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc         (pc),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  assign imem.imem_req  = (state == ST_FETCH) && !rst;
  assign imem.imem_addr = pc;

  // Responses only count against a request issued since the last reset
  assign resp   = (state == ST_WAIT) && outstanding && imem.imem_rvalid;
  assign expire = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= FAULT_NONE;
      count       <= '0;
      outstanding <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem.imem_ready) begin
            state       <= ST_WAIT;
            count       <= '0;
            outstanding <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (resp) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            outstanding <= 1'b0;
            state       <= ST_ISSUE;
          end else if (expire) begin
            count       <= count + CW'(1);
            outstanding <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= FAULT_TIMEOUT;
            state       <= ST_HALT;
          end else begin
            count <= count + CW'(1);
          end
        end
        ST_ISSUE: begin
          if (exec_ready) begin
            instr_valid <= 1'b0;
            if (misaligned) begin
              fault       <= 1'b1;
              fault_cause <= FAULT_MISALIGN;
              state       <= ST_HALT;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of next-PC vectors plus hand-written stall,
// timeout and reset-abort sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_ready  (exec_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] cur_pc;
    logic [31:0] exp_next;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept a request at exp_pc, answer one cycle later, and land in ISSUE.
  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] rdata, input string tag);
    check({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    check({tag, "_addr"}, bus.imem_addr, exp_pc);
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    check({tag, "_wait_req"}, 32'(bus.imem_req), 32'd0);
    check({tag, "_wait_valid"}, 32'(instr_valid), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = rdata;
    step();
    bus.imem_rvalid = 1'b0;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr, rdata);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_pc4"}, pc_plus4, exp_pc + 32'd4);
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 32'h0050_0093, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1] = '{2'b11, 32'h0000_0040, 32'h0000_0080, 32'h0000_0013, 32'h0000_0004, 32'h0000_0008, 1'b0};
    vecs[2] = '{2'b01, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFE00_0CE3, 32'h0000_0008, 32'h0000_0000, 1'b0};
    vecs[3] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFDF_F06F, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0};
    vecs[4] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 32'h0010_0093, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[5] = '{2'b10, 32'h0000_0000, 32'h0000_0201, 32'h0000_80E7, 32'h0000_0000, 32'h0000_0200, 1'b0};
    vecs[6] = '{2'b01, 32'h0000_0010, 32'h0000_0000, 32'h0000_0863, 32'h0000_0200, 32'h0000_0210, 1'b0};
    vecs[7] = '{2'b10, 32'h0000_0000, 32'h0000_0103, 32'h0000_8067, 32'h0000_0210, 32'h0000_0210, 1'b1};

    rst = 1'b1;
    exec_ready = 1'b0;
    pc_src = 2'b00;
    imm_ext = '0;
    alu_result = '0;
    bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    step();
    step();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    rst = 1'b0;
    #1;

    for (int unsigned i = 0; i < 8; i++) begin
      fetch(vecs[i].cur_pc, vecs[i].rdata, $sformatf("v%0d", i));
      pc_src     = vecs[i].src;
      imm_ext    = vecs[i].imm;
      alu_result = vecs[i].alu;
      exec_ready = 1'b1;
      step();
      exec_ready = 1'b0;
      pc_src     = 2'b10;
      alu_result = 32'h0000_0003;
      check($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      check($sformatf("v%0d_next_valid", i), 32'(instr_valid), 32'd0);
      if (vecs[i].exp_fault) begin
        check($sformatf("v%0d_cause", i), 32'(fault_cause), 32'd1);
        check($sformatf("v%0d_held_pc", i), pc, vecs[i].cur_pc);
        check($sformatf("v%0d_halt_req", i), 32'(bus.imem_req), 32'd0);
      end else begin
        check($sformatf("v%0d_next_addr", i), bus.imem_addr, vecs[i].exp_next);
        check($sformatf("v%0d_next_req", i), 32'(bus.imem_req), 32'd1);
      end
    end

    // Memory not ready for 5 cycles: request must hold steady
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int unsigned i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_req", i), 32'(bus.imem_req), 32'd1);
      check($sformatf("stall%0d_addr", i), bus.imem_addr, 32'h0);
      step();
    end
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    check("stall_accept", 32'(bus.imem_req), 32'd0);

    // No response: halt after 4 WAIT cycles, then late rvalid is ignored
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check($sformatf("to_wait%0d_fault", i), 32'(fault), 32'd0);
    end
    step();
    check("to_fault", 32'(fault), 32'd1);
    check("to_cause", 32'(fault_cause), 32'd2);
    check("to_req", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    check("late_valid", 32'(instr_valid), 32'd0);
    check("late_instr", instr, 32'h0);
    check("late_fault", 32'(fault), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("clr_pc", pc, 32'h0);
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_cause", 32'(fault_cause), 32'd0);
    check("clr_req", 32'(bus.imem_req), 32'd1);

    // rvalid on the last WAIT cycle beats the timeout; then a long ISSUE stall
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    step();
    step();
    step();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00A0_0113;
    step();
    bus.imem_rvalid = 1'b0;
    check("edge_valid", 32'(instr_valid), 32'd1);
    check("edge_fault", 32'(fault), 32'd0);
    check("edge_instr", instr, 32'h00A0_0113);
    pc_src = 2'b10;
    alu_result = 32'h0000_0103;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      check($sformatf("hold%0d_instr", i), instr, 32'h00A0_0113);
      check($sformatf("hold%0d_pc", i), pc, 32'h0);
      check($sformatf("hold%0d_valid", i), 32'(instr_valid), 32'd1);
    end
    pc_src = 2'b00;
    exec_ready = 1'b1;
    step();
    exec_ready = 1'b0;
    check("hold_next_addr", bus.imem_addr, 32'h4);
    check("hold_next_fault", 32'(fault), 32'd0);

    // Reset while waiting; the stale response right after reset is dropped
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0BAD;
    step();
    bus.imem_rvalid = 1'b0;
    check("abort_req", 32'(bus.imem_req), 32'd1);
    check("abort_addr", bus.imem_addr, 32'h0);
    check("abort_valid", 32'(instr_valid), 32'd0);
    check("abort_instr", instr, 32'h0);
    fetch(32'h0, 32'h0010_0073, "post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
